// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 key-schedule controller: default sizes,
// magic constants, controller state encoding and a small compile-time helper.
package rc5_pkg;

    localparam int unsigned RC5_W = 32;  // word width in bits
    localparam int unsigned RC5_T = 26;  // S table length (2r+2, r=12)
    localparam int unsigned RC5_C = 4;   // L array length in words (16-byte key)

    // Magic constants used by the S-array init block.
    localparam logic [RC5_W-1:0] RC5_PW = 32'hB7E1_5163;
    localparam logic [RC5_W-1:0] RC5_QW = 32'h9E37_79B9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_MIX_S = 3'd2,
        ST_MIX_L = 3'd3,
        ST_DONE  = 3'd4
    } rc5_state_e;

    // Larger of two values; sizes the mixing loop at elaboration time.
    function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational left rotate by a variable amount.
// Ports:
//   data_i  word to rotate
//   amt_i   rotation amount (only log2(w) bits, so it is implicitly mod w)
//   data_o  rotated word
module rc5_rotl #(
    parameter int unsigned w    = 32,
    parameter int unsigned sh_w = $clog2(w)
) (
    input  logic [w-1:0]    data_i,
    input  logic [sh_w-1:0] amt_i,
    output logic [w-1:0]    data_o
);

    logic [sh_w:0] rsh;

    // Amount 0 gives a right shift of w, which yields zero, so data passes through.
    always_comb begin
        rsh    = (sh_w + 1)'(w) - {1'b0, amt_i};
        data_o = (data_i << amt_i) | (data_i >> rsh);
    end

endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key-expansion sequencer. Releases the L/S prep blocks on start, waits
// for both to finish, then runs the 3*max(t,c) mixing loop alternating one
// S update and one L update per iteration over async-read/sync-write memories.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start                  one-cycle request; honoured only in IDLE or DONE
//   sub_rst                reset to the L/S prep blocks (1 = held)
//   l_done, s_done         prep block completion levels
//   S_address/S_rd_data    S memory read port (same-cycle data)
//   S_we/S_wr_data         S memory write port
//   L_address/L_rd_data    L memory read port (same-cycle data)
//   L_we/L_wr_data         L memory write port
//   busy, done             status: running / expanded table final
module rc5_key_schedule_ctrl
    import rc5_pkg::*;
#(
    parameter int unsigned w        = RC5_W,
    parameter int unsigned t        = RC5_T,
    parameter int unsigned t_length = $clog2(t),
    parameter int unsigned c        = RC5_C,
    parameter int unsigned c_length = $clog2(c)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                sub_rst,
    input  logic                l_done,
    input  logic                s_done,
    output logic [t_length-1:0] S_address,
    input  logic [w-1:0]        S_rd_data,
    output logic                S_we,
    output logic [w-1:0]        S_wr_data,
    output logic [c_length-1:0] L_address,
    input  logic [w-1:0]        L_rd_data,
    output logic                L_we,
    output logic [w-1:0]        L_wr_data,
    output logic                busy,
    output logic                done
);

    localparam int unsigned N_MIX = 3 * max_int(t, c);
    localparam int unsigned K_W   = $clog2(N_MIX);
    localparam int unsigned SH_W  = $clog2(w);

    rc5_state_e state_q, state_d;

    logic [w-1:0]        a_q, a_d;
    logic [w-1:0]        b_q, b_d;
    logic [t_length-1:0] i_q, i_d;
    logic [c_length-1:0] j_q, j_d;
    logic [K_W-1:0]      k_q, k_d;

    logic [w-1:0] ab;
    logic [w-1:0] sum_s;
    logic [w-1:0] sum_l;
    logic [w-1:0] new_a;
    logic [w-1:0] new_b;
    logic         restart;

    // Mixing arithmetic. In MIX_L, a_q already holds the A written in MIX_S.
    always_comb begin
        ab    = a_q + b_q;
        sum_s = S_rd_data + ab;
        sum_l = L_rd_data + ab;
    end

    rc5_rotl #(.w(w), .sh_w(SH_W)) u_rotl_s (
        .data_i (sum_s),
        .amt_i  (SH_W'(3)),
        .data_o (new_a)
    );

    rc5_rotl #(.w(w), .sh_w(SH_W)) u_rotl_l (
        .data_i (sum_l),
        .amt_i  (ab[SH_W-1:0]),
        .data_o (new_b)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_PREP;
            ST_PREP:          if (l_done && s_done) state_d = ST_MIX_S;
            ST_MIX_S:         state_d = ST_MIX_L;
            ST_MIX_L:         state_d = (k_q == K_W'(N_MIX - 1)) ? ST_DONE : ST_MIX_S;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Output decode; write ports are live only in the two mixing states.
    always_comb begin
        sub_rst   = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        S_address = i_q;
        S_we      = 1'b0;
        S_wr_data = '0;
        L_address = j_q;
        L_we      = 1'b0;
        L_wr_data = '0;
        case (state_q)
            ST_PREP: begin
                sub_rst = 1'b0;
                busy    = 1'b1;
            end
            ST_MIX_S: begin
                sub_rst   = 1'b0;
                busy      = 1'b1;
                S_we      = 1'b1;
                S_wr_data = new_a;
            end
            ST_MIX_L: begin
                sub_rst   = 1'b0;
                busy      = 1'b1;
                L_we      = 1'b1;
                L_wr_data = new_b;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Mixing registers: cleared on an accepted start, advanced in MIX states.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (restart) begin
            a_d = '0;
            b_d = '0;
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (state_q == ST_MIX_S) begin
            a_d = new_a;
        end else if (state_q == ST_MIX_L) begin
            b_d = new_b;
            i_d = (i_q == t_length'(t - 1)) ? '0 : i_q + t_length'(1);
            j_d = (j_q == c_length'(c - 1)) ? '0 : j_q + c_length'(1);
            k_d = k_q + K_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Bench for rc5_key_schedule_ctrl: behavioural S/L memories, a scoreboard of
// expected memory writes built from a software RC5 key expansion, and one
// task per scenario.
`timescale 1ns/1ps
module tb_rc5_key_schedule_ctrl;
    import rc5_pkg::*;

    localparam int unsigned W  = RC5_W;
    localparam int unsigned T  = RC5_T;
    localparam int unsigned C  = RC5_C;
    localparam int unsigned TL = $clog2(RC5_T);
    localparam int unsigned CL = $clog2(RC5_C);
    localparam int N_MIX = 3 * max_int(RC5_T, RC5_C);

    typedef struct packed {
        logic          is_s;
        logic [TL-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic l_done = 1'b0;
    logic s_done = 1'b0;
    logic sub_rst, S_we, L_we, busy, done;
    logic [TL-1:0] S_address;
    logic [CL-1:0] L_address;
    logic [W-1:0]  S_rd_data, S_wr_data, L_rd_data, L_wr_data;

    logic [W-1:0] s_mem [T];
    logic [W-1:0] l_mem [C];
    logic [W-1:0] s_init [T];
    logic [W-1:0] l_init [C];
    logic [W-1:0] gold_s [T];
    logic [W-1:0] gold_l [C];
    logic mem_load = 1'b0;

    wr_t sb_q [$];
    int n_tests = 0;
    int n_fail = 0;
    int s_wr_cnt = 0;
    int l_wr_cnt = 0;

    rc5_key_schedule_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub_rst   (sub_rst),
        .l_done    (l_done),
        .s_done    (s_done),
        .S_address (S_address),
        .S_rd_data (S_rd_data),
        .S_we      (S_we),
        .S_wr_data (S_wr_data),
        .L_address (L_address),
        .L_rd_data (L_rd_data),
        .L_we      (L_we),
        .L_wr_data (L_wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Async-read, sync-write memories, with a bulk load path for the bench.
    assign S_rd_data = (int'(S_address) < int'(T)) ? s_mem[S_address] : '0;
    assign L_rd_data = l_mem[L_address];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int x = 0; x < int'(T); x++) s_mem[x] <= s_init[x];
            for (int x = 0; x < int'(C); x++) l_mem[x] <= l_init[x];
        end else begin
            if (S_we && (int'(S_address) < int'(T))) s_mem[S_address] <= S_wr_data;
            if (L_we) l_mem[L_address] <= L_wr_data;
        end
    end

    // Write monitor: every DUT write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t obs, exp_w;
        if (S_we && L_we) begin
            n_tests++;
            n_fail++;
            $display("FAIL both_we: S_we=%0b L_we=%0b, required never both", S_we, L_we);
        end else if (S_we || L_we) begin
            obs.is_s = S_we;
            obs.addr = S_we ? S_address : TL'(L_address);
            obs.data = S_we ? S_wr_data : L_wr_data;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: is_s=%0b addr=%0d data=%h, required no write",
                         obs.is_s, obs.addr, obs.data);
            end else begin
                exp_w = sb_q.pop_front();
                if (obs !== exp_w) begin
                    n_fail++;
                    $display("FAIL write_seq: got is_s=%0b addr=%0d data=%h, required is_s=%0b addr=%0d data=%h",
                             obs.is_s, obs.addr, obs.data, exp_w.is_s, exp_w.addr, exp_w.data);
                end
            end
            if (S_we) s_wr_cnt++;
            else l_wr_cnt++;
        end
    end

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        int m;
        m = n % int'(W);
        if (m == 0) return x;
        return (x << m) | (x >> (int'(W) - m));
    endfunction

    // Standard S init plus the given key words, loaded into both memories.
    task automatic load_mem(input logic [W-1:0] k0, k1, k2, k3);
        s_init[0] = RC5_PW;
        for (int x = 1; x < int'(T); x++) s_init[x] = s_init[x-1] + RC5_QW;
        l_init[0] = k0;
        l_init[1] = k1;
        l_init[2] = k2;
        l_init[3] = k3;
        @(negedge clk);
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
    endtask

    // Software key expansion over the loaded init; queues every write.
    task automatic push_golden();
        logic [W-1:0] s [T];
        logic [W-1:0] l [C];
        logic [W-1:0] a, b, ab;
        wr_t e;
        int ii, jj;
        for (int x = 0; x < int'(T); x++) s[x] = s_init[x];
        for (int x = 0; x < int'(C); x++) l[x] = l_init[x];
        a = '0;
        b = '0;
        ii = 0;
        jj = 0;
        for (int k = 0; k < N_MIX; k++) begin
            a = rotl(s[ii] + a + b, 3);
            s[ii] = a;
            e.is_s = 1'b1; e.addr = TL'(ii); e.data = a;
            sb_q.push_back(e);
            ab = a + b;
            b = rotl(l[jj] + ab, int'(ab[4:0]));
            l[jj] = b;
            e.is_s = 1'b0; e.addr = TL'(jj); e.data = b;
            sb_q.push_back(e);
            ii = (ii + 1) % int'(T);
            jj = (jj + 1) % int'(C);
        end
        for (int x = 0; x < int'(T); x++) gold_s[x] = s[x];
        for (int x = 0; x < int'(C); x++) gold_l[x] = l[x];
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for the first write, then for done. -1 marks a timeout.
    task automatic run_to_done(output int entry_wait, output int mix_cycles);
        entry_wait = -1;
        mix_cycles = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (S_we === 1'b1) begin
                entry_wait = n;
                break;
            end
        end
        if (entry_wait < 0) return;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                mix_cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({sub_rst, busy, done, S_we, L_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_hold: {sub_rst,busy,done,S_we,L_we}=%b, required 10000",
                     {sub_rst, busy, done, S_we, L_we});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({sub_rst, busy, done, S_we, L_we, S_address, L_address} !== {5'b10000, TL'(0), CL'(0)}) begin
            n_fail++;
            $display("FAIL reset_idle: flags=%b S_address=%0d L_address=%0d, required 10000/0/0",
                     {sub_rst, busy, done, S_we, L_we}, S_address, L_address);
        end
    endtask

    task automatic test_prep_wait();
        int bad;
        l_done = 1'b0;
        s_done = 1'b0;
        load_mem('0, '0, '0, '0);
        push_golden();
        @(negedge clk);
        start = 1'b1;
        bad = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if ({busy, sub_rst, done, S_we, L_we} !== 5'b10000) bad++;
            if (cyc == 5) l_done = 1'b1;
            if (cyc == 30) s_done = 1'b1;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL prep_hold: %0d bad PREP cycles, required 0", bad);
        end
        @(negedge clk);
        n_tests++;
        if (S_we !== 1'b1) begin
            n_fail++;
            $display("FAIL mix_entry: S_we=%b the cycle after both done, required 1", S_we);
        end
        for (int n = 0; n < 400 && done !== 1'b1; n++) @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL prep_run_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_zero_key();
        int got;
        l_done = 1'b1;
        s_done = 1'b1;
        load_mem('0, '0, '0, '0);
        push_golden();
        pulse_start();
        got = 0;
        for (int n = 0; n < 20; n++) begin
            if (S_we === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (got !== 1) begin
            n_fail++;
            $display("FAIL zero_entry: no S write seen, required one");
        end
        n_tests++;
        if ({S_address, S_wr_data} !== {TL'(0), 32'hBF0A_8B1D}) begin
            n_fail++;
            $display("FAIL first_S: addr=%0d data=%h, required 0/bf0a8b1d", S_address, S_wr_data);
        end
        @(negedge clk);
        n_tests++;
        if ({L_we, L_address, L_wr_data} !== {1'b1, CL'(0), 32'hB7E1_5163}) begin
            n_fail++;
            $display("FAIL first_L: we=%b addr=%0d data=%h, required 1/0/b7e15163",
                     L_we, L_address, L_wr_data);
        end
        for (int n = 0; n < 400 && done !== 1'b1; n++) @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_full_run();
        int ew, mc, bad;
        l_done = 1'b0;
        s_done = 1'b0;
        load_mem(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
        push_golden();
        s_wr_cnt = 0;
        l_wr_cnt = 0;
        pulse_start();
        repeat (2) @(negedge clk);
        l_done = 1'b1;
        s_done = 1'b1;
        run_to_done(ew, mc);
        n_tests++;
        if (mc !== 156) begin
            n_fail++;
            $display("FAIL full_latency: done %0d cycles after MIX entry, required 156", mc);
        end
        n_tests++;
        if ({s_wr_cnt, l_wr_cnt} !== {N_MIX, N_MIX}) begin
            n_fail++;
            $display("FAIL full_counts: S writes=%0d L writes=%0d, required %0d each",
                     s_wr_cnt, l_wr_cnt, N_MIX);
        end
        n_tests++;
        if (sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL full_pending: %0d expected writes missing, required 0", sb_q.size());
        end
        bad = 0;
        for (int x = 0; x < int'(T); x++) if (s_mem[x] !== gold_s[x]) bad++;
        for (int x = 0; x < int'(C); x++) if (l_mem[x] !== gold_l[x]) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL full_final: %0d words differ (S[0]=%h vs %h), required 0",
                     bad, s_mem[0], gold_s[0]);
        end
        @(negedge clk);
        n_tests++;
        if ({done, busy, sub_rst} !== 3'b101) begin
            n_fail++;
            $display("FAIL full_status: {done,busy,sub_rst}=%b, required 101", {done, busy, sub_rst});
        end
    endtask

    task automatic test_rst_mid();
        int ew, mc, bad;
        l_done = 1'b1;
        s_done = 1'b1;
        load_mem(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
        push_golden();
        pulse_start();
        for (int n = 0; n < 20 && S_we !== 1'b1; n++) @(negedge clk);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 sb_q.delete();
        @(negedge clk);
        n_tests++;
        if ({busy, done, sub_rst, S_we, L_we} !== 5'b00100) begin
            n_fail++;
            $display("FAIL rst_abort: {busy,done,sub_rst,S_we,L_we}=%b, required 00100",
                     {busy, done, sub_rst, S_we, L_we});
        end
        // start together with rst: rst must win.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if ({busy, done, sub_rst} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_idle: {busy,done,sub_rst}=%b, required 001", {busy, done, sub_rst});
        end
        load_mem(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
        push_golden();
        pulse_start();
        run_to_done(ew, mc);
        n_tests++;
        if (mc !== 156) begin
            n_fail++;
            $display("FAIL rerun_latency: %0d, required 156", mc);
        end
        bad = 0;
        for (int x = 0; x < int'(T); x++) if (s_mem[x] !== gold_s[x]) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rerun_final: %0d S words differ, required 0", bad);
        end
    endtask

    task automatic test_start_ignore();
        int cnt, ew, mc, bad;
        l_done = 1'b1;
        s_done = 1'b1;
        load_mem(32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C);
        push_golden();
        pulse_start();
        for (int n = 0; n < 20 && S_we !== 1'b1; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 11;
        for (int n = 0; n < 400 && done !== 1'b1; n++) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (cnt !== 156) begin
            n_fail++;
            $display("FAIL busy_start_latency: done at %0d, required 156", cnt);
        end
        bad = 0;
        for (int x = 0; x < int'(T); x++) if (s_mem[x] !== gold_s[x]) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL busy_start_final: %0d S words differ, required 0", bad);
        end
        load_mem('0, 32'h1234_5678, '0, 32'hFFFF_FFFF);
        push_golden();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({done, busy, sub_rst} !== 3'b010) begin
            n_fail++;
            $display("FAIL done_restart: {done,busy,sub_rst}=%b, required 010", {done, busy, sub_rst});
        end
        run_to_done(ew, mc);
        n_tests++;
        if (mc !== 156) begin
            n_fail++;
            $display("FAIL done_restart_latency: %0d, required 156", mc);
        end
        bad = 0;
        for (int x = 0; x < int'(T); x++) if (s_mem[x] !== gold_s[x]) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL done_restart_final: %0d S words differ, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_prep_wait();
        test_zero_key();
        test_full_run();
        test_rst_mid();
        test_start_ignore();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rc5_key_schedule_ctrl.md
Name: rc5_key_schedule_ctrl

Overview:
Top-level sequencer for RC5 key expansion. It holds the key-bytes-to-words block and the S-array init block in reset until started, then waits for both to finish. It then runs the 3*max(t,c) mixing loop over the S and L word memories, using their asynchronous read and synchronous write ports. It asserts done when the expanded table S is final.

Parameters:
w, 32, word width in bits
t, 26, S table length (2r+2)
t_length, $clog2(t), S address width
c, 4, L array length in words
c_length, 2, L address width
n_mix, 3*max(t,c), mixing iterations (78 at defaults)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse to begin a key expansion; ignored unless IDLE or DONE
sub_rst  out  1  reset driven to L/S prep blocks; 1 holds them in reset
l_done  in  1  key-bytes-to-words finished, level
s_done  in  1  S-array init finished, level
S_address  out  t_length  S memory address (async read)
S_rd_data  in  w  S[S_address], same cycle
S_we  out  1  S write enable
S_wr_data  out  w  S write data
L_address  out  c_length  L memory address (async read)
L_rd_data  in  w  L[L_address], same cycle
L_we  out  1  L write enable
L_wr_data  out  w  L write data
busy  out  1  1 from accepted start until done
done  out  1  level, key schedule complete; cleared by next start or rst

Behaviour:
- Reset (sync, rst=1 at clock edge): state=IDLE, sub_rst=1, S_we=L_we=0, busy=0, done=0, A=B=0, i=j=0, k=0, addresses 0, write data 0.
- States: IDLE, PREP, MIX_S, MIX_L, DONE.
- IDLE/DONE + start: next cycle PREP, sub_rst=0, busy=1, done=0, A=B=i=j=k=0.
- PREP: waits for l_done && s_done, both sampled high in the same cycle, then goes to MIX_S. sub_rst stays 0. There is no timeout.
- MIX_S (1 cycle): S_address=i. new_A = rotl(S_rd_data + A + B, 3), sums mod 2^w. Drive S_we=1, S_wr_data=new_A combinationally. Register A<=new_A. Go to MIX_L.
- MIX_L (1 cycle): L_address=j. sum = L_rd_data + A + B, using the updated A. new_B = rotl(sum, (A+B)[log2(w)-1:0]). Drive L_we=1, L_wr_data=new_B. Register B<=new_B.
- MIX_L index updates: i<=(i==t-1)?0:i+1; j<=(j==c-1)?0:j+1; k<=k+1.
- MIX_L exit: if k==n_mix-1, go to DONE; else go to MIX_S.
- Latency: 2*n_mix cycles in MIX states (156 at defaults), plus PREP wait, plus 1 cycle from start to PREP.
- DONE: done=1, busy=0, sub_rst=1. S contents are valid for the encryption datapath.
- Write enables are never high outside MIX_S/MIX_L. S_we and L_we are never high in the same cycle.
- Rotation amount 0 passes data through unchanged. The rotation amount uses only the low log2(w) bits.
- start while busy: ignored.
- rst mid-operation: immediate return to IDLE on the next edge. Memory contents are left undefined-but-untouched and no further writes occur.
- start and rst in the same cycle: rst wins.
- l_done/s_done dropping during MIX: ignored.

Decomposition:
- Package rc5_pkg: w, qW/pW constants, state enum (IDLE, PREP, MIX_S, MIX_L, DONE), function max_int for n_mix.
- One sub-module, rc5_rotl: combinational variable left rotate, parameter w, shift width $clog2(w). It is instantiated twice (fixed amount 3 and variable amount).

Test Plan:
1. rst held 3 cycles then released -> sub_rst=1, busy=0, done=0, no S_we/L_we pulses.
2. start, then l_done at cycle 5 and s_done at cycle 30 -> PREP is held until both are high; first MIX_S begins the cycle after cycle 30.
3. All-zero key (L=0), S=standard init (S[0]=0xB7E15163) -> first MIX_S writes S[0]=0xBF0A8B1D; first MIX_L writes L[0]=0xB7E15163 (rotation amount 29).
4. Full run at defaults -> exactly 78 S writes and 78 L writes, and i/j wrap at 25->0 and 3->0. done rises 156 cycles after MIX entry. Final S matches a software RC5-32/12/16 golden model for key 0x00..0F.
5. rst pulsed at cycle 40 of mixing -> IDLE next cycle, writes stop, done=0. A new start reruns from i=j=k=0 and matches the golden model.
6. start pulsed during MIX and again in DONE -> the first is ignored with no restart; the second clears done and begins a new PREP.
